pixel_window_shifter: RTL and testbench

PIXEL_WINDOW_SHIFTER -- requirements
Module: pixel_window_shifter

---
 rtl/pixel_window_shifter.sv | 248 ++++++++++++++++++++++++
 tb/tb_pixel_window_shifter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_window_shifter.sv
// Sliding window of WIN_PIX pixels fed from a word FIFO through a two-word pixel staging buffer.
// Latency: an accepted word reaches staging two edges after acceptance; an accepted step is visible next cycle.
// Backpressure: in_ready_o is low while the FIFO is full; step_ack_o stays low until staging holds k pixels.
module pixel_window_shifter #(
  parameter int PIX_W      = 8,
  parameter int WIN_PIX    = 16,
  parameter int LANE_PIX   = 7,
  parameter int FIFO_DEPTH = 4,
  parameter int COLS       = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [LANE_PIX*PIX_W-1:0]    in_data_i,
  input  logic                         start_i,
  input  logic                         step_i,
  input  logic                         step2_i,
  output logic                         step_ack_o,
  output logic                         win_valid_o,
  output logic [WIN_PIX*PIX_W-1:0]     win_data_o,
  output logic                         row_end_o,
  output logic                         busy_o,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level_o
);

  localparam int LANE_W = LANE_PIX * PIX_W;
  localparam int WIN_W  = WIN_PIX * PIX_W;
  localparam int STG_W  = 2 * LANE_W;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int STG_CW = $clog2(2 * LANE_PIX + 1);
  localparam int FILL_W = $clog2(WIN_PIX + 1);
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // ------------------------------------------------------------------
  // Input word FIFO
  // ------------------------------------------------------------------
  logic [LANE_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign push       = in_valid_i && !fifo_full;

  assign in_ready_o   = !fifo_full;
  assign fifo_level_o = level_q;

  // FIFO storage: contents need no reset, the level alone says what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= in_data_i;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Pixel staging buffer: oldest pixel in the LSBs
  // ------------------------------------------------------------------
  logic [STG_W-1:0]  stg_q, stg_d;
  logic [STG_CW-1:0] stg_cnt_q, stg_cnt_d;
  logic [1:0]        consume;

  // Refill only when a whole word fits, so the count never exceeds two words.
  assign pop = !fifo_empty && (stg_cnt_q <= STG_CW'(LANE_PIX));

  // Remove consumed pixels from the bottom, then append a popped word above the survivors.
  always_comb begin
    stg_d     = stg_q >> (int'(consume) * PIX_W);
    stg_cnt_d = stg_cnt_q - STG_CW'(consume);
    if (pop) begin
      stg_d     = stg_d | ({{LANE_W{1'b0}}, fifo_mem[rd_ptr_q]} << (int'(stg_cnt_d) * PIX_W));
      stg_cnt_d = stg_cnt_d + STG_CW'(LANE_PIX);
    end
  end

  // Staging register and pixel count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stg_q     <= '0;
      stg_cnt_q <= '0;
    end else begin
      stg_q     <= stg_d;
      stg_cnt_q <= stg_cnt_d;
    end
  end

  // ------------------------------------------------------------------
  // Control FSM
  // ------------------------------------------------------------------
  logic [FILL_W-1:0] fill_cnt_q;
  logic [COL_W-1:0]  col_cnt_q;
  logic [1:0]        step_k;
  logic              clear_win;
  logic              row_done;

  assign step_k = step2_i ? 2'd2 : 2'd1;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, step handshake and how many staged pixels enter the window this cycle.
  always_comb begin
    state_d    = state_q;
    step_ack_o = 1'b0;
    consume    = 2'd0;
    clear_win  = 1'b0;
    row_done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_FILL;
          clear_win = 1'b1;
        end
      end
      S_FILL: begin
        if (start_i) begin
          clear_win = 1'b1;
        end else if (stg_cnt_q != '0) begin
          consume = 2'd1;
          if (fill_cnt_q == FILL_W'(WIN_PIX - 1)) begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        // A restart outranks any pending step.
        if (start_i) begin
          state_d   = S_FILL;
          clear_win = 1'b1;
        end else if (step_i && (stg_cnt_q >= STG_CW'(step_k))) begin
          step_ack_o = 1'b1;
          consume    = step_k;
          if (col_cnt_q == COL_W'(COLS - 1)) begin
            row_done = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign win_valid_o = (state_q == S_RUN);
  assign busy_o      = (state_q == S_FILL) || (state_q == S_RUN);

  // ------------------------------------------------------------------
  // Window datapath
  // ------------------------------------------------------------------
  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] win_shift;

  // Window shifted right by the consumed pixels, the next staged pixels entering at the MSB end.
  always_comb begin
    win_shift = win_q;
    case (consume)
      2'd1: win_shift = (win_q >> PIX_W)
                      | ({{(WIN_W - PIX_W){1'b0}}, stg_q[PIX_W-1:0]} << (WIN_W - PIX_W));
      2'd2: win_shift = (win_q >> (2 * PIX_W))
                      | ({{(WIN_W - 2 * PIX_W){1'b0}}, stg_q[2*PIX_W-1:0]} << (WIN_W - 2 * PIX_W));
      default: win_shift = win_q;
    endcase
  end

  // Window register: cleared by a (re)start, otherwise updated whenever pixels are consumed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_q <= '0;
    end else if (clear_win) begin
      win_q <= '0;
    end else if (consume != 2'd0) begin
      win_q <= win_shift;
    end
  end

  // Fill and column counters; the column counter returns to zero on the last step of a row.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fill_cnt_q <= '0;
      col_cnt_q  <= '0;
    end else if (clear_win) begin
      fill_cnt_q <= '0;
      col_cnt_q  <= '0;
    end else begin
      if ((state_q == S_FILL) && (consume != 2'd0)) begin
        fill_cnt_q <= fill_cnt_q + 1'b1;
      end
      if (step_ack_o) begin
        col_cnt_q <= row_done ? '0 : col_cnt_q + 1'b1;
      end
    end
  end

  // Row-end pulse follows the final accepted step of a row by one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_end_o <= 1'b0;
    end else begin
      row_end_o <= row_done;
    end
  end

  assign win_data_o = win_q;

endmodule

// File: tb/tb_pixel_window_shifter.sv
// Bench for pixel_window_shifter: directed table plus randomized traffic against a pixel-stream model.
// Latency: checks registered outputs 1 ns after the rising edge, combinational handshakes 2 ns after the falling edge.
// Backpressure: pushes wait on in_ready_o and steps are held until step_ack_o, every wait bounded.
module tb_pixel_window_shifter;

  localparam int PIX_W  = 8;
  localparam int WINP   = 16;
  localparam int LANEP  = 7;
  localparam int LANE_W = LANEP * PIX_W;
  localparam int WIN_W  = WINP * PIX_W;
  localparam int COLS_M = 64;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              in_valid_i = 1'b0;
  logic [LANE_W-1:0] in_data_i = '0;
  logic              start_i = 1'b0;
  logic              step_i = 1'b0;
  logic              step2_i = 1'b0;

  logic              in_ready_o, step_ack_o, win_valid_o, row_end_o, busy_o;
  logic [WIN_W-1:0]  win_data_o;
  logic [2:0]        fifo_level_o;

  logic              in_ready3, step_ack3, win_valid3, row_end3, busy3;
  logic [WIN_W-1:0]  win_data3;
  logic [2:0]        level3;

  pixel_window_shifter dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_data_i(in_data_i), .start_i(start_i), .step_i(step_i), .step2_i(step2_i),
    .step_ack_o(step_ack_o), .win_valid_o(win_valid_o), .win_data_o(win_data_o),
    .row_end_o(row_end_o), .busy_o(busy_o), .fifo_level_o(fifo_level_o)
  );

  pixel_window_shifter #(.COLS(3)) dut3 (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready3),
    .in_data_i(in_data_i), .start_i(start_i), .step_i(step_i), .step2_i(step2_i),
    .step_ack_o(step_ack3), .win_valid_o(win_valid3), .win_data_o(win_data3),
    .row_end_o(row_end3), .busy_o(busy3), .fifo_level_o(level3)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic       step;
    logic       step2;
    logic       push;
    logic       exp_ack;
    logic [7:0] exp_lsb;
  } vec_t;

  vec_t tbl [10];

  // Reference model state: every accepted pixel in order, and how many the window has passed.
  typedef enum int { M_IDLE, M_FILL, M_RUN } mstate_t;
  logic [7:0] stream [$];
  int         consumed;
  int         fill_base;
  int         cols;
  mstate_t    mstate;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [LANE_W-1:0] word_of(input logic [7:0] b);
    logic [LANE_W-1:0] w;
    for (int i = 0; i < LANEP; i++) w[i*8 +: 8] = b + 8'(i);
    return w;
  endfunction

  function automatic logic [WIN_W-1:0] win_of(input logic [7:0] b);
    logic [WIN_W-1:0] w;
    for (int i = 0; i < WINP; i++) w[i*8 +: 8] = b + 8'(i);
    return w;
  endfunction

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0; in_valid_i = 1'b0; start_i = 1'b0; step_i = 1'b0; step2_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic push_word(input logic [LANE_W-1:0] w);
    int n;
    @(negedge clk_i);
    in_valid_i = 1'b1;
    in_data_i  = w;
    #2;
    n = 0;
    while (!in_ready_o && n < 20) begin
      @(negedge clk_i); #2;
      n++;
    end
    chk("push_accept", in_ready_o, 1'b1);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!win_valid_o && n < 100) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk(name, win_valid_o, 1'b1);
  endtask

  initial begin
    int n;
    int k;
    int avail;
    int streak;
    logic push_ok, ack, exp_row_end, illegal;
    logic [63:0] rnd64;
    logic [LANE_W-1:0] pushed;
    logic [WIN_W-1:0] expw;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h01};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h03};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h04};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h04};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h04};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h04};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h04};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h06};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h06};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h07};

    // Reset state
    do_reset();
    #1;
    chk("rst_win_valid", win_valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_level", fifo_level_o, 3'd0);
    chk("rst_ready", in_ready_o, 1'b1);
    chk("rst_row_end", row_end_o, 1'b0);
    chk("rst_win_data", win_data_o, '0);

    // Fill from three words of pixels 0x00..0x14
    push_word(word_of(8'h00));
    push_word(word_of(8'h07));
    push_word(word_of(8'h0E));
    @(negedge clk_i); start_i = 1'b1;
    @(posedge clk_i); #1; start_i = 1'b0;
    chk("fill_busy", busy_o, 1'b1);
    chk("fill_not_valid", win_valid_o, 1'b0);
    n = 0;
    while (!win_valid_o && n < 100) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("fill_valid", win_valid_o, 1'b1);
    chk("fill_cycles_ge16", (n >= 16), 1'b1);
    chk("fill_window", win_data_o, win_of(8'h00));

    // Step table: single, double, starved double step, refill, resume
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      step_i = tbl[i].step; step2_i = tbl[i].step2;
      in_valid_i = tbl[i].push; in_data_i = word_of(8'h15);
      #2;
      chk($sformatf("vec%0d_ack", i), step_ack_o, tbl[i].exp_ack);
      if (tbl[i].push) chk($sformatf("vec%0d_ready", i), in_ready_o, 1'b1);
      @(posedge clk_i); #1;
      in_valid_i = 1'b0; step_i = 1'b0;
      chk($sformatf("vec%0d_win", i), win_data_o, win_of(tbl[i].exp_lsb));
      chk($sformatf("vec%0d_valid", i), win_valid_o, 1'b1);
    end

    // FIFO fills to depth with no start; extra word refused
    do_reset();
    push_word(word_of(8'h20));
    push_word(word_of(8'h27));
    repeat (3) @(posedge clk_i);
    for (int i = 0; i < 4; i++) push_word(word_of(8'(8'h40 + 8'(i * 7))));
    chk("full_level", fifo_level_o, 3'd4);
    chk("full_ready", in_ready_o, 1'b0);
    @(negedge clk_i); in_valid_i = 1'b1; in_data_i = word_of(8'h60);
    #2;
    chk("fifth_ready", in_ready_o, 1'b0);
    @(posedge clk_i); #1; in_valid_i = 1'b0;
    chk("fifth_level", fifo_level_o, 3'd4);

    // Short row on the COLS=3 instance
    do_reset();
    push_word(word_of(8'h00));
    push_word(word_of(8'h07));
    push_word(word_of(8'h0E));
    @(negedge clk_i); start_i = 1'b1;
    @(posedge clk_i); #1; start_i = 1'b0;
    n = 0;
    while (!win_valid3 && n < 100) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("c3_valid", win_valid3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i); step_i = 1'b1; step2_i = 1'b0;
      #2;
      chk($sformatf("c3_ack%0d", i), step_ack3, 1'b1);
      @(posedge clk_i); #1; step_i = 1'b0;
      chk($sformatf("c3_row_end%0d", i), row_end3, (i == 2));
    end
    chk("c3_end_valid", win_valid3, 1'b0);
    chk("c3_end_busy", busy3, 1'b0);
    @(posedge clk_i); #1;
    chk("c3_row_end_drop", row_end3, 1'b0);

    // Asynchronous reset mid-row with words waiting
    do_reset();
    push_word(word_of(8'h00));
    push_word(word_of(8'h07));
    push_word(word_of(8'h0E));
    @(negedge clk_i); start_i = 1'b1;
    @(posedge clk_i); #1; start_i = 1'b0;
    wait_valid("ar_valid");
    n = 0;
    while (fifo_level_o != 3'd2 && n < 6) begin
      push_word(word_of(8'h80));
      n++;
    end
    chk("ar_level2", fifo_level_o, 3'd2);
    #2; rst_ni = 1'b0;
    #1;
    chk("ar_win_valid", win_valid_o, 1'b0);
    chk("ar_win_data", win_data_o, '0);
    chk("ar_busy", busy_o, 1'b0);
    chk("ar_level", fifo_level_o, 3'd0);
    chk("ar_row_end", row_end_o, 1'b0);
    chk("ar_ack", step_ack_o, 1'b0);
    @(negedge clk_i); rst_ni = 1'b1;
    #1;
    chk("ar_ready", in_ready_o, 1'b1);
    @(negedge clk_i); start_i = 1'b1;
    @(posedge clk_i); #1; start_i = 1'b0;
    repeat (30) @(posedge clk_i);
    #1;
    chk("ar_stuck_busy", busy_o, 1'b1);
    chk("ar_stuck_valid", win_valid_o, 1'b0);

    // Randomized traffic against the stream model
    do_reset();
    stream.delete();
    consumed = 0; fill_base = 0; cols = 0; mstate = M_IDLE;
    streak = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk_i);
      in_valid_i = ($urandom_range(0, 9) < 6);
      rnd64 = {$urandom, $urandom};
      in_data_i = rnd64[LANE_W-1:0];
      if (!step_i) begin
        step_i  = $urandom_range(0, 1);
        step2_i = $urandom_range(0, 1);
      end
      start_i = 1'b0;
      if (mstate == M_IDLE && $urandom_range(0, 3) == 0) start_i = 1'b1;
      else if (mstate == M_RUN && $urandom_range(0, 199) == 0) start_i = 1'b1;
      #2;
      push_ok = in_valid_i && in_ready_o;
      pushed  = in_data_i;
      ack     = step_ack_o;
      k       = step2_i ? 2 : 1;
      avail   = stream.size() - consumed;
      chk("rnd_ready", in_ready_o, (fifo_level_o != 3'd4));
      illegal = ack && !(mstate == M_RUN && !start_i && step_i && avail >= k);
      chk("rnd_ack_legal", illegal, 1'b0);
      if (mstate == M_RUN && step_i && !start_i && !ack) streak++;
      else streak = 0;
      if (mstate == M_RUN && step_i && !start_i)
        chk("rnd_step_live", (streak > 30 && avail >= 16), 1'b0);
      @(posedge clk_i); #1;
      if (push_ok) for (int i = 0; i < LANEP; i++) stream.push_back(pushed[i*8 +: 8]);
      exp_row_end = 1'b0;
      if (start_i) begin
        mstate = M_FILL; fill_base = consumed; cols = 0; streak = 0;
      end else if (ack) begin
        consumed += k;
        step_i = 1'b0;
        if (cols == COLS_M - 1) begin
          cols = 0; mstate = M_IDLE; exp_row_end = 1'b1;
        end else begin
          cols++;
        end
      end
      if (mstate == M_FILL && win_valid_o) begin
        mstate = M_RUN;
        consumed = fill_base + WINP;
        chk("rnd_fill_avail", (consumed <= stream.size()), 1'b1);
      end
      chk("rnd_row_end", row_end_o, exp_row_end);
      chk("rnd_busy", busy_o, (mstate != M_IDLE));
      chk("rnd_valid", win_valid_o, (mstate == M_RUN));
      if (mstate == M_RUN && consumed <= stream.size()) begin
        for (int i = 0; i < WINP; i++) expw[i*8 +: 8] = stream[consumed - WINP + i];
        chk("rnd_window", win_data_o, expw);
      end
    end
    start_i = 1'b0; step_i = 1'b0; in_valid_i = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
